// File: rtl/ps2_key_if.sv
// PS/2 line pair in, decoded ps2_key event word and error pulses out.
interface ps2_key_if;
   logic        ps2_clk;
   logic        ps2_dat;
   logic [10:0] ps2_key;
   logic        err_parity;
   logic        err_frame;

   modport master (
      output ps2_clk, ps2_dat,
      input  ps2_key, err_parity, err_frame
   );

   modport slave (
      input  ps2_clk, ps2_dat,
      output ps2_key, err_parity, err_frame
   );
endinterface

// File: rtl/ps2_key_encoder.sv
// Raw PS/2 clock/data to 11-bit {toggle, pressed, ext, code} key event word:
// synchronizer, clock deglitcher, frame receiver and scan-code prefix decoder.
module ps2_key_encoder #(
   parameter int unsigned FILTER_LEN = 8,
   parameter int unsigned TIMEOUT    = 24576
) (
   input  logic     clk_sys,
   input  logic     reset,
   ps2_key_if.slave bus
);

   localparam int unsigned RUN_W  = 8;
   localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);
   localparam int unsigned BIT_W  = 4;
   localparam int unsigned SKIP_W = 3;
   localparam int unsigned KEY_W  = 11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_E0,
      S_F0,
      S_E0F0,
      S_SKIP
   } state_t;

   logic              clk_s1, clk_s2, dat_s1, dat_s2;
   logic              filt, filt_q;
   logic [RUN_W-1:0]  run;
   logic              fall_c;

   logic [BIT_W-1:0]  bit_cnt;
   logic [7:0]        shreg;
   logic              par;
   logic [TMO_W-1:0]  tmo;
   logic              byte_valid;
   logic              err_frame_q, err_parity_q;

   state_t              state, state_n;
   logic [SKIP_W-1:0]   skip, skip_n;
   logic                emit_c, ext_c, brk_c, ignore_c;
   logic [KEY_W-1:0]    key_q;

   // Two-stage synchronizers, idle-high preset
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         clk_s1 <= 1'b1;
         clk_s2 <= 1'b1;
         dat_s1 <= 1'b1;
         dat_s2 <= 1'b1;
      end else begin
         clk_s1 <= bus.ps2_clk;
         clk_s2 <= clk_s1;
         dat_s1 <= bus.ps2_dat;
         dat_s2 <= dat_s1;
      end
   end

   // Deglitcher: level moves only after FILTER_LEN consecutive differing samples
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         filt   <= 1'b1;
         filt_q <= 1'b1;
         run    <= '0;
      end else begin
         filt_q <= filt;
         if (clk_s2 != filt) begin
            if (run == RUN_W'(FILTER_LEN - 1)) begin
               filt <= clk_s2;
               run  <= '0;
            end else begin
               run <= run + RUN_W'(1);
            end
         end else begin
            run <= '0;
         end
      end
   end

   assign fall_c = filt_q & ~filt;

   // Frame receiver; a falling edge always beats timeout expiry
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         bit_cnt      <= '0;
         shreg        <= '0;
         par          <= 1'b0;
         tmo          <= '0;
         byte_valid   <= 1'b0;
         err_frame_q  <= 1'b0;
         err_parity_q <= 1'b0;
      end else begin
         byte_valid   <= 1'b0;
         err_frame_q  <= 1'b0;
         err_parity_q <= 1'b0;
         if (fall_c) begin
            tmo <= '0;
            case (bit_cnt)
               BIT_W'(0): begin
                  if (!dat_s2) bit_cnt <= BIT_W'(1);
               end
               BIT_W'(9): begin
                  par     <= dat_s2;
                  bit_cnt <= bit_cnt + BIT_W'(1);
               end
               BIT_W'(10): begin
                  bit_cnt <= '0;
                  if (!dat_s2)                 err_frame_q  <= 1'b1;
                  else if (~^{shreg, par})     err_parity_q <= 1'b1;
                  else                         byte_valid   <= 1'b1;
               end
               default: begin
                  shreg   <= {dat_s2, shreg[7:1]};
                  bit_cnt <= bit_cnt + BIT_W'(1);
               end
            endcase
         end else if (bit_cnt != '0) begin
            if (tmo == TMO_W'(TIMEOUT - 1)) begin
               bit_cnt     <= '0;
               tmo         <= '0;
               err_frame_q <= 1'b1;
            end else begin
               tmo <= tmo + TMO_W'(1);
            end
         end else begin
            tmo <= '0;
         end
      end
   end

   always_comb begin
      ignore_c = shreg inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         skip  <= '0;
         key_q <= '0;
      end else begin
         state <= state_n;
         skip  <= skip_n;
         if (emit_c) key_q <= {~key_q[10], ~brk_c, ext_c, shreg};
      end
   end

   // Prefix decoder; any error drops pending prefixes
   always_comb begin
      state_n = state;
      skip_n  = skip;
      emit_c  = 1'b0;
      ext_c   = 1'b0;
      brk_c   = 1'b0;
      if (err_frame_q || err_parity_q) begin
         state_n = S_IDLE;
         skip_n  = '0;
      end else if (byte_valid) begin
         case (state)
            S_IDLE: begin
               if (shreg == 8'hE0)      state_n = S_E0;
               else if (shreg == 8'hF0) state_n = S_F0;
               else if (shreg == 8'hE1) begin
                  state_n = S_SKIP;
                  skip_n  = SKIP_W'(7);
               end else if (!ignore_c)  emit_c = 1'b1;
            end
            S_E0: begin
               if (shreg == 8'hF0) state_n = S_E0F0;
               else if (shreg != 8'hE0) begin
                  emit_c  = 1'b1;
                  ext_c   = 1'b1;
                  state_n = S_IDLE;
               end
            end
            S_F0: begin
               if (shreg != 8'hE0 && shreg != 8'hF0) begin
                  emit_c  = 1'b1;
                  brk_c   = 1'b1;
                  state_n = S_IDLE;
               end
            end
            S_E0F0: begin
               if (shreg != 8'hE0 && shreg != 8'hF0) begin
                  emit_c  = 1'b1;
                  ext_c   = 1'b1;
                  brk_c   = 1'b1;
                  state_n = S_IDLE;
               end
            end
            S_SKIP: begin
               skip_n = skip - SKIP_W'(1);
               if (skip == SKIP_W'(1)) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
         endcase
      end
   end

   assign bus.ps2_key    = key_q;
   assign bus.err_parity = err_parity_q;
   assign bus.err_frame  = err_frame_q;

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Bench for ps2_key_encoder: bit-banged PS/2 frames against a prefix-flag
// reference model of the scan-code rules.
module tb_ps2_key_encoder;
   localparam int unsigned FL = 8;
   localparam int unsigned TO = 500;
   localparam int unsigned H  = 40;

   logic clk_sys = 1'b0;
   logic reset;
   ps2_key_if bus ();

   ps2_key_encoder #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
      .clk_sys (clk_sys),
      .reset   (reset),
      .bus     (bus)
   );

   always #5 clk_sys = ~clk_sys;

   int checks = 0;
   int failures = 0;
   int unsigned cyc = 0;
   always @(posedge clk_sys) cyc <= cyc + 1;

   // Output monitor: toggle count, error-high cycle counts, event timestamps
   logic [10:0] prev_key = '0;
   int toggles = 0, perr_cycles = 0, ferr_cycles = 0;
   int unsigned key_chg_cyc = 0, perr_cyc = 0, ferr_cyc = 0, drive_cyc = 0;
   always @(posedge clk_sys) begin
      #1;
      if (!reset) begin
         if (bus.ps2_key !== prev_key) begin
            key_chg_cyc = cyc;
            if (bus.ps2_key[10] !== prev_key[10]) toggles++;
         end
         if (bus.err_parity) begin perr_cycles++; perr_cyc = cyc; end
         if (bus.err_frame)  begin ferr_cycles++; ferr_cyc = cyc; end
      end
      prev_key = bus.ps2_key;
   end

   // Reference model: pending prefix flags plus Pause skip count
   logic        m_ext = 1'b0, m_brk = 1'b0;
   int          m_skip = 0;
   logic [10:0] m_key = '0;
   int          m_emits = 0;

   function automatic void model_clear();
      m_ext = 1'b0; m_brk = 1'b0; m_skip = 0;
   endfunction

   function automatic void model_byte(input logic [7:0] b);
      logic idle;
      idle = !m_ext && !m_brk;
      if (m_skip > 0) m_skip--;
      else if (b == 8'hE0) begin
         if (!(m_brk && !m_ext)) m_ext = 1'b1;
      end else if (b == 8'hF0) m_brk = 1'b1;
      else if (idle && b == 8'hE1) m_skip = 7;
      else if (idle && (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF})) begin
      end else begin
         m_key = {~m_key[10], ~m_brk, m_ext, b};
         m_emits++;
         model_clear();
      end
   endfunction

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   // Sends the first nbits bits of a frame; drive_cyc marks the last falling edge
   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
      logic [10:0] bits;
      bits[0]   = 1'b0;
      bits[8:1] = b;
      bits[9]   = (~^b) ^ bad_par;
      bits[10]  = ~bad_stop;
      for (int i = 0; i < nbits; i++) begin
         bus.ps2_dat = bits[i];
         wait_cyc(H);
         bus.ps2_clk = 1'b0;
         drive_cyc = cyc;
         wait_cyc(H);
         bus.ps2_clk = 1'b1;
      end
      wait_cyc(H);
      bus.ps2_dat = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.ps2_clk = 1'b1;
      bus.ps2_dat = 1'b1;
      wait_cyc(5);
      reset = 1'b0;
      wait_cyc(5);
      checks++; if (bus.ps2_key !== 11'h000) begin failures++; $display("FAIL reset_key: got %h expected 000", bus.ps2_key); end
      checks++; if (bus.err_parity !== 1'b0) begin failures++; $display("FAIL reset_err_parity: got %b expected 0", bus.err_parity); end
      checks++; if (bus.err_frame !== 1'b0) begin failures++; $display("FAIL reset_err_frame: got %b expected 0", bus.err_frame); end
   endtask

   task automatic test_single();
      int t0, p0, f0;
      t0 = toggles; p0 = perr_cycles; f0 = ferr_cycles;
      send_frame(8'h1C, 0, 0, 11);
      model_byte(8'h1C);
      checks++; if (bus.ps2_key !== 11'h61C) begin failures++; $display("FAIL single_key: got %h expected 61C", bus.ps2_key); end
      checks++; if (bus.ps2_key !== m_key) begin failures++; $display("FAIL single_model: got %h expected %h", bus.ps2_key, m_key); end
      checks++; if (key_chg_cyc - drive_cyc !== FL + 4) begin failures++; $display("FAIL single_latency: got %0d expected %0d", key_chg_cyc - drive_cyc, FL + 4); end
      checks++; if (toggles - t0 !== 1) begin failures++; $display("FAIL single_toggles: got %0d expected 1", toggles - t0); end
      checks++; if ((perr_cycles - p0) + (ferr_cycles - f0) !== 0) begin failures++; $display("FAIL single_errs: got %0d expected 0", (perr_cycles - p0) + (ferr_cycles - f0)); end
   endtask

   task automatic test_prefix();
      int t0;
      logic [10:0] k0;
      t0 = toggles; k0 = bus.ps2_key;
      send_frame(8'hE0, 0, 0, 11); model_byte(8'hE0);
      send_frame(8'hF0, 0, 0, 11); model_byte(8'hF0);
      checks++; if (toggles - t0 !== 0 || bus.ps2_key !== k0) begin failures++; $display("FAIL prefix_hold: got %h/%0d expected %h/0", bus.ps2_key, toggles - t0, k0); end
      send_frame(8'h75, 0, 0, 11); model_byte(8'h75);
      checks++; if (bus.ps2_key !== {~k0[10], 2'b01, 8'h75}) begin failures++; $display("FAIL prefix_key: got %h expected %h", bus.ps2_key, {~k0[10], 2'b01, 8'h75}); end
      checks++; if (toggles - t0 !== 1) begin failures++; $display("FAIL prefix_toggles: got %0d expected 1", toggles - t0); end
   endtask

   task automatic test_parity();
      int p0, t0;
      logic [10:0] k0;
      p0 = perr_cycles; t0 = toggles; k0 = bus.ps2_key;
      send_frame(8'h1C, 1, 0, 11); model_clear();
      checks++; if (perr_cycles - p0 !== 1) begin failures++; $display("FAIL parity_pulse: got %0d cycles expected 1", perr_cycles - p0); end
      checks++; if (perr_cyc - drive_cyc !== FL + 3) begin failures++; $display("FAIL parity_latency: got %0d expected %0d", perr_cyc - drive_cyc, FL + 3); end
      checks++; if (bus.ps2_key !== k0 || toggles != t0) begin failures++; $display("FAIL parity_key_hold: got %h expected %h", bus.ps2_key, k0); end
      send_frame(8'hF0, 0, 0, 11); model_byte(8'hF0);
      send_frame(8'h1C, 0, 0, 11); model_byte(8'h1C);
      checks++; if (bus.ps2_key !== {~k0[10], 2'b00, 8'h1C}) begin failures++; $display("FAIL parity_break: got %h expected %h", bus.ps2_key, {~k0[10], 2'b00, 8'h1C}); end
      // E0 pending, then a bad frame must drop it
      send_frame(8'hE0, 0, 0, 11); model_byte(8'hE0);
      send_frame(8'h55, 1, 0, 11); model_clear();
      send_frame(8'h1C, 0, 0, 11); model_byte(8'h1C);
      checks++; if (bus.ps2_key !== m_key) begin failures++; $display("FAIL parity_stale_prefix: got %h expected %h", bus.ps2_key, m_key); end
   endtask

   task automatic test_stop();
      int f0;
      logic [10:0] k0;
      f0 = ferr_cycles; k0 = bus.ps2_key;
      send_frame(8'h2A, 0, 1, 11); model_clear();
      checks++; if (ferr_cycles - f0 !== 1) begin failures++; $display("FAIL stop_pulse: got %0d cycles expected 1", ferr_cycles - f0); end
      checks++; if (bus.ps2_key !== k0) begin failures++; $display("FAIL stop_key_hold: got %h expected %h", bus.ps2_key, k0); end
   endtask

   task automatic test_glitch_timeout();
      int f0, t0;
      f0 = ferr_cycles; t0 = toggles;
      bus.ps2_dat = 1'b0;
      for (int i = 0; i < 20; i++) begin
         bus.ps2_clk = 1'b0;
         wait_cyc((i == 0) ? 1 : ((i == 1) ? FL - 1 : $urandom_range(1, FL - 1)));
         bus.ps2_clk = 1'b1;
         wait_cyc($urandom_range(FL + 2, 30));
      end
      bus.ps2_dat = 1'b1;
      wait_cyc(TO + 100);
      checks++; if (ferr_cycles - f0 !== 0 || toggles != t0) begin failures++; $display("FAIL glitch_counted: got %0d errs expected 0", ferr_cycles - f0); end
      send_frame(8'h5A, 0, 0, 5);
      wait_cyc(TO + 50);
      model_clear();
      checks++; if (ferr_cycles - f0 !== 1) begin failures++; $display("FAIL timeout_pulse: got %0d cycles expected 1", ferr_cycles - f0); end
      checks++; if (ferr_cyc - drive_cyc !== FL + 3 + TO) begin failures++; $display("FAIL timeout_latency: got %0d expected %0d", ferr_cyc - drive_cyc, FL + 3 + TO); end
      send_frame(8'h29, 0, 0, 11); model_byte(8'h29);
      checks++; if (bus.ps2_key !== m_key || bus.ps2_key[9] !== 1'b1) begin failures++; $display("FAIL timeout_next_frame: got %h expected %h", bus.ps2_key, m_key); end
   endtask

   task automatic test_pause();
      logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
      int t0;
      logic [10:0] k0;
      t0 = toggles; k0 = bus.ps2_key;
      foreach (seq[i]) begin
         send_frame(seq[i], 0, 0, 11);
         model_byte(seq[i]);
      end
      checks++; if (toggles - t0 !== 0) begin failures++; $display("FAIL pause_swallow: got %0d toggles expected 0", toggles - t0); end
      send_frame(8'h16, 0, 0, 11); model_byte(8'h16);
      checks++; if (bus.ps2_key !== {~k0[10], 2'b10, 8'h16}) begin failures++; $display("FAIL pause_after: got %h expected %h", bus.ps2_key, {~k0[10], 2'b10, 8'h16}); end
      checks++; if (toggles - t0 !== 1) begin failures++; $display("FAIL pause_toggles: got %0d expected 1", toggles - t0); end
   endtask

   task automatic test_random();
      int t0, e0, r;
      logic [7:0] b;
      logic [7:0] pool [11] = '{8'hE0, 8'hF0, 8'hE1, 8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
      t0 = toggles; e0 = m_emits;
      for (int i = 0; i < 30; i++) begin
         r = $urandom_range(0, 99);
         if (r < 40) b = pool[$urandom_range(0, 1)];
         else if (r < 45) b = pool[2];
         else if (r < 55) b = pool[$urandom_range(3, 10)];
         else b = 8'($urandom);
         send_frame(b, 0, 0, 11);
         model_byte(b);
         checks++; if (bus.ps2_key !== m_key || toggles - t0 != m_emits - e0) begin
            failures++;
            $display("FAIL random_%0d byte %h: got %h/%0d expected %h/%0d", i, b, bus.ps2_key, toggles - t0, m_key, m_emits - e0);
         end
      end
   endtask

   task automatic test_reset_mid();
      int f0, p0;
      send_frame(8'hC3, 0, 0, 4);
      bus.ps2_dat = 1'b0;
      wait_cyc(H);
      bus.ps2_clk = 1'b0;
      wait_cyc(H / 2);
      reset = 1'b1;
      bus.ps2_clk = 1'b1;
      bus.ps2_dat = 1'b1;
      wait_cyc(3);
      reset = 1'b0;
      m_key = '0;
      model_clear();
      wait_cyc(2);
      checks++; if (bus.ps2_key !== 11'h000) begin failures++; $display("FAIL reset_mid_key: got %h expected 000", bus.ps2_key); end
      f0 = ferr_cycles; p0 = perr_cycles;
      send_frame(8'h3B, 0, 0, 11); model_byte(8'h3B);
      checks++; if (bus.ps2_key !== 11'h63B) begin failures++; $display("FAIL reset_mid_next: got %h expected 63B", bus.ps2_key); end
      wait_cyc(TO + 50);
      checks++; if ((ferr_cycles - f0) + (perr_cycles - p0) !== 0) begin failures++; $display("FAIL reset_mid_errs: got %0d expected 0", (ferr_cycles - f0) + (perr_cycles - p0)); end
   endtask

   initial begin
      reset = 1'b1;
      bus.ps2_clk = 1'b1;
      bus.ps2_dat = 1'b1;
      test_reset();
      test_single();
      test_prefix();
      test_parity();
      test_stop();
      test_glitch_timeout();
      test_pause();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
